// File: rtl/mc_ctrl_pkg.sv
// Shared constants, state encoding and control-bus layout for the multicycle MIPS control unit.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic [1:0] reg_dst;
    logic       reg_wr;
    logic       alu_src;
    logic [2:0] alu;
    logic       mem_wr;
    logic [1:0] mem_to_reg;
    logic       ir_wr;
    logic       pc_wr;
    logic       jump;
    logic       jr;
    logic       beq;
    logic       bne;
  } ctrl_t;

  // Instructions that proceed from DECODE into EXEC.
  function automatic logic is_exec_op(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_SLT, FN_JR};
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from current state and instruction fields to the datapath control bus.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit HAS_JAL = 1'b1
) (
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_wr = 1'b1;
          ctrl.pc_wr = 1'b1;
        end
      end
      S_DECODE: begin
        if (op == OP_J || (HAS_JAL && op == OP_JAL)) begin
          ctrl.jump  = 1'b1;
          ctrl.pc_wr = 1'b1;
        end
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            case (funct)
              FN_ADD: ctrl.alu = ALU_ADD;
              FN_SUB: ctrl.alu = ALU_SUB;
              FN_SLT: ctrl.alu = ALU_SLT;
              FN_JR: begin
                ctrl.jr    = 1'b1;
                ctrl.pc_wr = 1'b1;
              end
              default: ;
            endcase
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ctrl.alu     = ALU_ADD;
            ctrl.alu_src = 1'b1;
          end
          OP_XORI: begin
            ctrl.alu     = ALU_XOR;
            ctrl.alu_src = 1'b1;
          end
          OP_BEQ: begin
            ctrl.alu = ALU_SUB;
            ctrl.beq = 1'b1;
          end
          OP_BNE: begin
            ctrl.alu = ALU_SUB;
            ctrl.bne = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_wr  = (op == OP_SW);
      end
      S_WB: begin
        ctrl.reg_wr = 1'b1;
        case (op)
          OP_RTYPE: ctrl.reg_dst = 2'd1;
          OP_LW:    ctrl.mem_to_reg = 2'd1;
          OP_JAL: begin
            ctrl.reg_dst    = 2'd2;
            ctrl.mem_to_reg = 2'd2;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: state sequencing, memory handshake timeout and retired count.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32,
  parameter bit          HAS_JAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [1:0]       RegDst,
  output logic             RegWr,
  output logic             ALUSrc,
  output logic [2:0]       ALUcntrl,
  output logic             MemWr,
  output logic [1:0]       MemToReg,
  output logic             IRWr,
  output logic             PCWr,
  output logic             jump,
  output logic             jr,
  output logic             beq,
  output logic             bne,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, fn_q, op_eff;
  logic [7:0]       wait_q;
  logic             wait_expired;
  logic             set_illegal, set_timeout;
  logic             illegal_q, timeout_q;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  // DECODE drives the jump strobes from the live opcode; every later state uses the latched copy.
  assign op_eff       = (state_q == S_DECODE) ? opcode : op_q;
  assign wait_expired = (wait_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (wait_expired) begin
          state_d     = S_ERR;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_J) state_d = S_FETCH;
        else if (HAS_JAL && opcode == OP_JAL) state_d = S_WB;
        else if (is_exec_op(opcode, funct)) state_d = S_EXEC;
        else begin
          state_d     = S_ERR;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW:   state_d = S_MEM;
          OP_BEQ, OP_BNE: state_d = S_FETCH;
          OP_RTYPE:       state_d = (fn_q == FN_JR) ? S_FETCH : S_WB;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
        else if (wait_expired) begin
          state_d     = S_ERR;
          set_timeout = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (state_d != state_q) wait_q <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM) wait_q <= wait_q + 8'd1;
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
        retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  mc_ctrl_decode #(.HAS_JAL(HAS_JAL)) u_decode (
    .state    (state_q),
    .op       (op_eff),
    .funct    (fn_q),
    .mem_ready(mem_ready),
    .ctrl     (ctrl)
  );

  assign mem_req  = ctrl.mem_req;
  assign RegDst   = ctrl.reg_dst;
  assign RegWr    = ctrl.reg_wr;
  assign ALUSrc   = ctrl.alu_src;
  assign ALUcntrl = ctrl.alu;
  assign MemWr    = ctrl.mem_wr;
  assign MemToReg = ctrl.mem_to_reg;
  assign IRWr     = ctrl.ir_wr;
  assign PCWr     = ctrl.pc_wr;
  assign jump     = ctrl.jump;
  assign jr       = ctrl.jr;
  assign beq      = ctrl.beq;
  assign bne      = ctrl.bne;
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction cycle scripts built from the instruction rules, directed plus random.
module tb_mc_ctrl_fsm;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic       mem_req;
    logic [1:0] reg_dst;
    logic       reg_wr;
    logic       alu_src;
    logic [2:0] alu;
    logic       mem_wr;
    logic [1:0] mem_to_reg;
    logic       ir_wr;
    logic       pc_wr;
    logic       jump;
    logic       jr;
    logic       beq;
    logic       bne;
  } ctl_t;

  typedef struct packed {
    logic       rdy;
    logic       dec;
    logic [2:0] st;
    ctl_t       c;
  } step_t;

  logic clk = 1'b0, rst_n = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;

  logic mem_req, RegWr, ALUSrc, MemWr, IRWr, PCWr, jump, jr, beq, bne, illegal, timeout;
  logic [1:0] RegDst, MemToReg;
  logic [2:0] ALUcntrl, state;
  logic [31:0] retired;

  logic b_mem_req, b_RegWr, b_ALUSrc, b_MemWr, b_IRWr, b_PCWr, b_jump, b_jr, b_beq, b_bne;
  logic b_illegal, b_timeout;
  logic [1:0] b_RegDst, b_MemToReg;
  logic [2:0] b_ALUcntrl, b_state, b_retired;

  int total = 0, bad = 0;
  int unsigned ret_exp = 0;
  step_t q[$];
  ctl_t obs_c;

  logic [11:0] tbl [12] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2A}, {6'h00, 6'h08},
    {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00},
    {6'h08, 6'h00}, {6'h0E, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}
  };

  always #5 clk = ~clk;

  assign obs_c = {mem_req, RegDst, RegWr, ALUSrc, ALUcntrl, MemWr, MemToReg,
                  IRWr, PCWr, jump, jr, beq, bne};

  mc_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(32), .HAS_JAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc(ALUSrc), .ALUcntrl(ALUcntrl),
    .MemWr(MemWr), .MemToReg(MemToReg), .IRWr(IRWr), .PCWr(PCWr), .jump(jump), .jr(jr),
    .beq(beq), .bne(bne), .state(state), .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  mc_ctrl_fsm #(.TIMEOUT(15), .CNT_W(3), .HAS_JAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .RegDst(b_RegDst), .RegWr(b_RegWr), .ALUSrc(b_ALUSrc),
    .ALUcntrl(b_ALUcntrl), .MemWr(b_MemWr), .MemToReg(b_MemToReg), .IRWr(b_IRWr),
    .PCWr(b_PCWr), .jump(b_jump), .jr(b_jr), .beq(b_beq), .bne(b_bne), .state(b_state),
    .illegal(b_illegal), .timeout(b_timeout), .retired(b_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic rdy, input logic dec, input logic [2:0] st, input ctl_t c);
    q.push_back('{rdy: rdy, dec: dec, st: st, c: c});
  endfunction

  function automatic void push_wb(input logic [1:0] dst, input logic [1:0] m2r);
    ctl_t c = '0;
    c.reg_wr = 1'b1;
    c.reg_dst = dst;
    c.mem_to_reg = m2r;
    push(1'($urandom), 1'b0, 3'd5, c);
  endfunction

  // Builds the expected per-cycle script; returns 0 retired, 1 illegal, 2 handshake timeout.
  function automatic int build(input logic [5:0] op, input logic [5:0] fn,
                               input int unsigned wf, input int unsigned wm);
    ctl_t c;
    bit r = (op == 6'h00);
    bit arith = r && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A);
    q.delete();
    c = '0;
    c.mem_req = 1'b1;
    for (int unsigned i = 0; i < wf && i < TO; i++) push(1'b0, 1'b0, 3'd1, c);
    if (wf >= TO) return 2;
    c.ir_wr = 1'b1;
    c.pc_wr = 1'b1;
    push(1'b1, 1'b0, 3'd1, c);
    c = '0;
    if (op == 6'h02 || op == 6'h03) begin
      c.jump = 1'b1;
      c.pc_wr = 1'b1;
    end
    push(1'($urandom), 1'b1, 3'd2, c);
    if (op == 6'h02) return 0;
    if (op == 6'h03) begin
      push_wb(2'd2, 2'd2);
      return 0;
    end
    c = '0;
    if (arith) begin
      c.alu = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 : 3'd3;
      push(1'($urandom), 1'b0, 3'd3, c);
      push_wb(2'd1, 2'd0);
      return 0;
    end
    if (r && fn == 6'h08) begin
      c.jr = 1'b1;
      c.pc_wr = 1'b1;
      push(1'($urandom), 1'b0, 3'd3, c);
      return 0;
    end
    if (op == 6'h08 || op == 6'h0E) begin
      c.alu_src = 1'b1;
      c.alu = (op == 6'h08) ? 3'd0 : 3'd2;
      push(1'($urandom), 1'b0, 3'd3, c);
      push_wb(2'd0, 2'd0);
      return 0;
    end
    if (op == 6'h04 || op == 6'h05) begin
      c.alu = 3'd1;
      c.beq = (op == 6'h04);
      c.bne = (op == 6'h05);
      push(1'($urandom), 1'b0, 3'd3, c);
      return 0;
    end
    if (op == 6'h23 || op == 6'h2B) begin
      c.alu_src = 1'b1;
      push(1'($urandom), 1'b0, 3'd3, c);
      c = '0;
      c.mem_req = 1'b1;
      c.mem_wr = (op == 6'h2B);
      for (int unsigned i = 0; i < wm && i < TO; i++) push(1'b0, 1'b0, 3'd4, c);
      if (wm >= TO) return 2;
      push(1'b1, 1'b0, 3'd4, c);
      if (op == 6'h23) push_wb(2'd0, 2'd1);
      return 0;
    end
    return 1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_ctrl", 32'(obs_c), 0);
    chk("rst_retired", retired, 0);
    chk("rst_flags", {30'd0, illegal, timeout}, 0);
    ret_exp = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_state", 32'(state), 0);
    chk("idle_ctrl", 32'(obs_c), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int unsigned wf,
                     input int unsigned wm, input int unsigned abort_at);
    int res;
    step_t e;
    res = build(op, fn, wf, wm);
    chk("retired", retired, ret_exp);
    foreach (q[i]) begin
      e = q[i];
      mem_ready = e.rdy;
      opcode = e.dec ? op : ($urandom_range(0, 1) ? 6'h3F : 6'($urandom));
      funct = e.dec ? fn : 6'($urandom);
      #1;
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'(obs_c), 32'(e.c));
      chk("flags", {30'd0, illegal, timeout}, 0);
      if (i == abort_at) begin
        do_reset();
        return;
      end
      @(posedge clk);
      #1;
    end
    if (res == 0) ret_exp++;
    else begin
      repeat (3) begin
        mem_ready = 1'($urandom);
        opcode = 6'($urandom);
        funct = 6'($urandom);
        #1;
        chk("err_state", 32'(state), 6);
        chk("err_ctrl", 32'(obs_c), 0);
        chk("err_flags", {30'd0, illegal, timeout}, (res == 1) ? 2 : 1);
        @(posedge clk);
        #1;
      end
      do_reset();
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    int unsigned k;
    #2;
    do_reset();
    run(6'h00, 6'h20, 0, 0, 999);   // ADD
    run(6'h23, 6'h11, 0, 3, 999);   // LW, 3 wait states in MEM
    run(6'h2B, 6'h00, 0, 0, 999);   // SW, opcode garbage after DECODE
    run(6'h03, 6'h00, 0, 0, 999);   // JAL
    run(6'h02, 6'h15, 1, 0, 999);   // J
    run(6'h00, 6'h20, 3, 0, 999);   // ready arrives on the last allowed cycle
    run(6'h00, 6'h20, TO, 0, 999);  // FETCH timeout
    run(6'h23, 6'h00, 0, 2, 999);
    run(6'h23, 6'h00, 0, TO, 999);  // MEM timeout
    run(6'h00, 6'h21, 0, 0, 999);   // illegal funct
    run(6'h00, 6'h22, 0, 0, 999);
    run(6'h3F, 6'h00, 0, 0, 999);   // illegal opcode
    run(6'h0E, 6'h00, 2, 0, 999);
    run(6'h04, 6'h00, 0, 0, 2);     // reset during BEQ EXEC
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 11);
      op = tbl[k][11:6];
      fn = (op == 6'h00) ? tbl[k][5:0] : 6'($urandom);
      run(op, fn, ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 2),
          ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3), 999);
    end
    do_reset();
    for (int n = 0; n < 9; n++) run(6'h02, 6'h00, 0, 0, 999);
    chk("b_retired_wrap", 32'(b_retired), 1);
    chk("b_state_fetch", 32'(b_state), 1);
    run(6'h03, 6'h00, 0, 0, 999);
    chk("b_jal_state", 32'(b_state), 6);
    chk("b_jal_illegal", {30'd0, b_illegal, b_timeout}, 2);
    chk("b_err_ctrl", {29'd0, b_RegWr, b_PCWr, b_jump}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
